// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write scheduler: default widths
// and the scheduler state encoding.
package regfile_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 2 ** DEF_ADDR_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid request found scanning upward
// from ptr (with wrap-around), producing a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int         scan_pos;
  logic [PTR_W-1:0] scan_idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    scan_pos    = 0;
    scan_idx    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_pos = (int'(ptr) + off) % NUM_REQ;
      scan_idx = PTR_W'(scan_pos);
      if (!grant_valid && req[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
        grant_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the regfile write port: clears every register after reset, then shares
// the port round-robin between writeback requesters and flags read hazards.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int              NUM_REQ    = 2,
  parameter int              DATA_W     = DEF_DATA_W,
  parameter int              ADDR_W     = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [ADDR_W-1:0]         readRegA,
  input  logic [ADDR_W-1:0]         readRegB,
  output logic                      hazardA,
  output logic                      hazardB,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         writeReg,
  output logic [DATA_W-1:0]         writeData,
  output logic                      initDone
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                init_done_q, init_done_d;

  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_valid;
  logic                run_active;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic                pend_a, pend_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Grants are withheld while reset is asserted so no requester loses a write
  // that the reset is about to drop.
  assign run_active = (state_q == RUN) && !reset;
  assign req_ready  = grant & {NUM_REQ{run_active}};
  assign sel_reg    = req_reg[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_data   = req_data[int'(grant_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    init_done_d  = (state_q == RUN);
    case (state_q)
      INIT: begin
        reg_write_d  = 1'b1;
        write_reg_d  = init_cnt_q;
        write_data_d = INIT_VALUE;
        init_cnt_d   = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A grant to register 0 still uses the slot, but $zero is never written.
        if (grant_valid) begin
          reg_write_d  = (sel_reg != '0);
          write_reg_d  = sel_reg;
          write_data_d = sel_data;
          rr_ptr_d     = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      rr_ptr_q     <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      init_done_q  <= init_done_d;
    end
  end

  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (req_reg[i*ADDR_W +: ADDR_W] == readRegA)) pend_a = 1'b1;
      if (req_valid[i] && (req_reg[i*ADDR_W +: ADDR_W] == readRegB)) pend_b = 1'b1;
    end
    hazardA = (state_q == INIT) ||
              ((readRegA != '0) && ((reg_write_q && (write_reg_q == readRegA)) || pend_a));
    hazardB = (state_q == INIT) ||
              ((readRegB != '0) && ((reg_write_q && (write_reg_q == readRegB)) || pend_b));
  end

  assign RegWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign initDone  = init_done_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: init sweep, arbitration order,
// $zero suppression, hazard flags and mid-operation reset.
module tb_regfile_write_scheduler;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [9:0]  req_reg;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic [4:0]  readRegA;
  logic [4:0]  readRegB;
  logic        hazardA;
  logic        hazardB;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        initDone;

  int checkCount = 0;
  int passCount  = 0;

  regfile_write_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .req_ready (req_ready),
    .readRegA  (readRegA),
    .readRegB  (readRegB),
    .hazardA   (hazardA),
    .hazardB   (hazardB),
    .RegWrite  (RegWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .initDone  (initDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [4:0] reg0, input logic [31:0] data0,
                               input logic [4:0] reg1, input logic [31:0] data1);
    req_valid = valid;
    req_reg   = {reg1, reg0};
    req_data  = {data1, data0};
  endtask

  initial begin
    reset    = 1'b1;
    readRegA = '0;
    readRegB = '0;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_RegWrite", {31'b0, RegWrite}, 32'd0);
    checkOutput("rst_writeReg", {27'b0, writeReg}, 32'd0);
    checkOutput("rst_writeData", writeData, 32'd0);
    checkOutput("rst_initDone", {31'b0, initDone}, 32'd0);
    checkOutput("rst_ready", {30'b0, req_ready}, 32'd0);

    // Init sweep with both requesters clamouring; none may be granted.
    reset = 1'b0;
    applyStimulus(2'b11, 5'd9, 32'h99, 5'd10, 32'hAA);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("init_RegWrite_%0d", k), {31'b0, RegWrite}, 32'd1);
      checkOutput($sformatf("init_writeReg_%0d", k), {27'b0, writeReg}, k);
      checkOutput($sformatf("init_writeData_%0d", k), writeData, 32'd0);
      checkOutput($sformatf("init_initDone_%0d", k), {31'b0, initDone}, 32'd0);
      if (k < 31) begin
        checkOutput($sformatf("init_ready_%0d", k), {30'b0, req_ready}, 32'd0);
        checkOutput($sformatf("init_hazardA_%0d", k), {31'b0, hazardA}, 32'd1);
      end
      if (k == 30) applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("run_initDone", {31'b0, initDone}, 32'd1);
    checkOutput("run_idle_RegWrite", {31'b0, RegWrite}, 32'd0);

    // Single requester 0, pointer at 0.
    applyStimulus(2'b01, 5'd3, 32'h000000AD, 5'd0, 32'h0);
    #1 checkOutput("t2_ready", {30'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1 applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("t2_RegWrite", {31'b0, RegWrite}, 32'd1);
    checkOutput("t2_writeReg", {27'b0, writeReg}, 32'd3);
    checkOutput("t2_writeData", writeData, 32'hAD);

    // Pointer now at 1: write to $zero is granted but suppressed.
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF);
    #1 checkOutput("t4_ready", {30'b0, req_ready}, 32'h2);
    @(posedge clk);
    #1 applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("t4_RegWrite", {31'b0, RegWrite}, 32'd0);

    // Pointer back at 0: both requesters always valid, grants alternate.
    applyStimulus(2'b11, 5'd4, 32'h11, 5'd5, 32'h22);
    for (int c = 0; c < 4; c++) begin
      #1 checkOutput($sformatf("t3_ready_%0d", c), {30'b0, req_ready}, (c % 2 == 0) ? 32'h1 : 32'h2);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("t3_RegWrite_%0d", c), {31'b0, RegWrite}, 32'd1);
      checkOutput($sformatf("t3_writeReg_%0d", c), {27'b0, writeReg}, (c % 2 == 0) ? 32'd4 : 32'd5);
      checkOutput($sformatf("t3_writeData_%0d", c), writeData, (c % 2 == 0) ? 32'h11 : 32'h22);
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // Hazards: pending request, then in-flight write, then clear.
    readRegA = 5'd7;
    readRegB = 5'd0;
    applyStimulus(2'b01, 5'd7, 32'h77, 5'd0, 32'h0);
    #1;
    checkOutput("t5_pend_hazardA", {31'b0, hazardA}, 32'd1);
    checkOutput("t5_pend_hazardB", {31'b0, hazardB}, 32'd0);
    checkOutput("t5_ready", {30'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1 applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("t5_writeReg", {27'b0, writeReg}, 32'd7);
    checkOutput("t5_flight_hazardA", {31'b0, hazardA}, 32'd1);
    checkOutput("t5_flight_hazardB", {31'b0, hazardB}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_clear_hazardA", {31'b0, hazardA}, 32'd0);
    readRegB = 5'd12;
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd12, 32'hC);
    #1 checkOutput("t5_req1_hazardB", {31'b0, hazardB}, 32'd1);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    readRegA = 5'd0;
    readRegB = 5'd0;

    // Reset while requester 0 is being granted: write dropped, sweep restarts.
    applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
    #1 checkOutput("t6_ready_before", {30'b0, req_ready}, 32'h1);
    reset = 1'b1;
    #1 checkOutput("t6_ready_in_reset", {30'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1 applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("t6_RegWrite", {31'b0, RegWrite}, 32'd0);
    checkOutput("t6_initDone", {31'b0, initDone}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("t6_sweep_RegWrite_%0d", k), {31'b0, RegWrite}, 32'd1);
      checkOutput($sformatf("t6_sweep_writeReg_%0d", k), {27'b0, writeReg}, k);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
